// File: rtl/fpu_pkg.sv
// Shared FPU writeback types and constants.
// Opcodes, fflags bit positions and the buffered entry layout.
package fpu_pkg;

    localparam int FP_XLEN = 64;
    localparam int FP_RD_W = 5;

    localparam logic [2:0] FP_TO_INT_SIGNED   = 3'b000;
    localparam logic [2:0] FP_TO_INT_UNSIGNED = 3'b001;
    localparam logic [2:0] INT_TO_FP_SIGNED   = 3'b010;
    localparam logic [2:0] INT_TO_FP_UNSIGNED = 3'b011;
    localparam logic [2:0] FP_SGNJ            = 3'b100;
    localparam logic [2:0] FP_SGNJN           = 3'b101;
    localparam logic [2:0] FP_SGNJX           = 3'b110;
    localparam logic [2:0] FP_TO_FP           = 3'b111;

    localparam int FFLAG_NV = 4;
    localparam int FFLAG_DZ = 3;
    localparam int FFLAG_OF = 2;
    localparam int FFLAG_UF = 1;
    localparam int FFLAG_NX = 0;

    typedef struct packed {
        logic [FP_XLEN-1:0] data;
        logic [FP_RD_W-1:0] rd;
        logic               to_int;
        logic [4:0]         flags;
    } wb_entry_t;

    localparam int WB_ENTRY_W = $bits(wb_entry_t);

endpackage

// File: rtl/fpu_skid_buf2.sv
// Two-entry valid/ready buffer with registered outputs and flush.
// Head register drives the output; tail holds the skid entry.
module fpu_skid_buf2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic [1:0]   count_q;
    logic [1:0]   count_d;
    logic [W-1:0] head_q;
    logic [W-1:0] tail_q;
    logic         rdy_q;
    logic         push;
    logic         pop;
    logic         has_head;

    assign has_head  = (count_q != 2'd0);
    assign push      = in_valid & rdy_q & ~flush;
    assign pop       = has_head & out_ready & ~flush;
    assign out_valid = has_head & ~flush;
    assign out_data  = head_q;
    assign in_ready  = rdy_q;

    // Occupancy after this edge; flush empties the buffer.
    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = 2'd0;
        end else if (push & ~pop) begin
            count_d = count_q + 2'd1;
        end else if (pop & ~push) begin
            count_d = count_q - 2'd1;
        end
    end

    // Occupancy and registered ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= 2'd0;
            rdy_q   <= 1'b1;
        end else begin
            count_q <= count_d;
            rdy_q   <= (count_d < 2'd2);
        end
    end

    // Head loads new data when empty or draining, else promotes tail.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
        end else if (push && (count_q == 2'd0 || pop)) begin
            head_q <= in_data;
        end else if (pop && count_q == 2'd2) begin
            head_q <= tail_q;
        end
    end

    // Tail captures when head is occupied and not leaving.
    always_ff @(posedge clk) begin
        if (rst) begin
            tail_q <= '0;
        end else if (push && !pop && count_q == 2'd1) begin
            tail_q <= in_data;
        end
    end

endmodule

// File: rtl/fpu_cvt_wb.sv
// Writeback stage for the FPU convert/sign-injection unit.
// Formats results for the target regfile and keeps sticky fflags.
module fpu_cvt_wb
    import fpu_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int RD_W  = 5,
    parameter int DEPTH = 2
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            IN_VALID,
    output logic            IN_READY,
    input  logic [2:0]      IN_OPERATION,
    input  logic            IN_SP_DP,
    input  logic [RD_W-1:0] IN_RD,
    input  logic [XLEN-1:0] IN_RESULT,
    input  logic            IN_INVALID,
    input  logic            IN_OVERFLOW,
    input  logic            IN_UNDERFLOW,
    input  logic            IN_INEXACT,
    input  logic            FLUSH,
    output logic            WB_VALID,
    input  logic            WB_READY,
    output logic [XLEN-1:0] WB_DATA,
    output logic [RD_W-1:0] WB_RD,
    output logic            WB_TO_INT,
    input  logic            CSR_WE,
    input  logic [4:0]      CSR_WDATA,
    output logic [4:0]      FFLAGS
);

    if (DEPTH != 2) begin : g_bad_depth
        $error("fpu_cvt_wb supports DEPTH=2 only");
    end

    wb_entry_t cap;
    wb_entry_t head;
    logic      is_f2i;
    logic      sp_dest;
    logic      nan_box;
    logic      retire;
    logic [4:0] fflags_q;

    assign is_f2i  = (IN_OPERATION[2:1] == 2'b00);
    // FP->FP converts to the opposite precision of the source.
    assign sp_dest = (IN_OPERATION == FP_TO_FP) ? IN_SP_DP : ~IN_SP_DP;
    assign nan_box = ~is_f2i & sp_dest;

    // Build the buffered entry with destination formatting applied.
    always_comb begin
        cap        = '0;
        cap.rd     = IN_RD;
        cap.flags[FFLAG_NV] = IN_INVALID;
        cap.flags[FFLAG_DZ] = 1'b0;
        cap.flags[FFLAG_OF] = IN_OVERFLOW;
        cap.flags[FFLAG_UF] = IN_UNDERFLOW;
        cap.flags[FFLAG_NX] = IN_INEXACT;
        unique case (1'b1)
            is_f2i: begin
                cap.to_int = 1'b1;
                cap.data   = {{32{IN_RESULT[31]}}, IN_RESULT[31:0]};
            end
            nan_box: begin
                cap.data = {32'hFFFF_FFFF, IN_RESULT[31:0]};
            end
            default: begin
                cap.data = IN_RESULT;
            end
        endcase
    end

    fpu_skid_buf2 #(
        .W (WB_ENTRY_W)
    ) u_buf (
        .clk       (CLK),
        .rst       (RST),
        .flush     (FLUSH),
        .in_valid  (IN_VALID),
        .in_ready  (IN_READY),
        .in_data   (cap),
        .out_valid (WB_VALID),
        .out_ready (WB_READY),
        .out_data  (head)
    );

    assign WB_DATA   = head.data;
    assign WB_RD     = head.rd;
    assign WB_TO_INT = head.to_int;
    assign retire    = WB_VALID & WB_READY;
    assign FFLAGS    = fflags_q;

    // Sticky flags: CSR write merged with flags of the retiring entry.
    always_ff @(posedge CLK) begin
        if (RST) begin
            fflags_q <= 5'b0;
        end else begin
            fflags_q <= (CSR_WE ? CSR_WDATA : fflags_q)
                      | (retire ? head.flags : 5'b0);
        end
    end

endmodule

// File: tb/tb_fpu_cvt_wb.sv
// Directed bench for fpu_cvt_wb.
// Hand-computed vectors for formatting, buffering, flags and flush.
module tb_fpu_cvt_wb;

    logic        CLK = 1'b0;
    logic        RST;
    logic        IN_VALID;
    logic        IN_READY;
    logic [2:0]  IN_OPERATION;
    logic        IN_SP_DP;
    logic [4:0]  IN_RD;
    logic [63:0] IN_RESULT;
    logic        IN_INVALID;
    logic        IN_OVERFLOW;
    logic        IN_UNDERFLOW;
    logic        IN_INEXACT;
    logic        FLUSH;
    logic        WB_VALID;
    logic        WB_READY;
    logic [63:0] WB_DATA;
    logic [4:0]  WB_RD;
    logic        WB_TO_INT;
    logic        CSR_WE;
    logic [4:0]  CSR_WDATA;
    logic [4:0]  FFLAGS;

    int checks = 0;
    int errors = 0;

    fpu_cvt_wb dut (
        .CLK          (CLK),
        .RST          (RST),
        .IN_VALID     (IN_VALID),
        .IN_READY     (IN_READY),
        .IN_OPERATION (IN_OPERATION),
        .IN_SP_DP     (IN_SP_DP),
        .IN_RD        (IN_RD),
        .IN_RESULT    (IN_RESULT),
        .IN_INVALID   (IN_INVALID),
        .IN_OVERFLOW  (IN_OVERFLOW),
        .IN_UNDERFLOW (IN_UNDERFLOW),
        .IN_INEXACT   (IN_INEXACT),
        .FLUSH        (FLUSH),
        .WB_VALID     (WB_VALID),
        .WB_READY     (WB_READY),
        .WB_DATA      (WB_DATA),
        .WB_RD        (WB_RD),
        .WB_TO_INT    (WB_TO_INT),
        .CSR_WE       (CSR_WE),
        .CSR_WDATA    (CSR_WDATA),
        .FFLAGS       (FFLAGS)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic [2:0] op, input logic sp,
                         input logic [4:0] rd, input logic [63:0] res,
                         input logic [3:0] fl);
        IN_VALID     = 1'b1;
        IN_OPERATION = op;
        IN_SP_DP     = sp;
        IN_RD        = rd;
        IN_RESULT    = res;
        {IN_INVALID, IN_OVERFLOW, IN_UNDERFLOW, IN_INEXACT} = fl;
    endtask

    task automatic idle_in();
        IN_VALID = 1'b0;
        {IN_INVALID, IN_OVERFLOW, IN_UNDERFLOW, IN_INEXACT} = 4'b0;
    endtask

    // Capture one vector with WB_READY high and check its formatting.
    task automatic fmt(input string tag, input logic [2:0] op,
                       input logic sp, input logic [63:0] res,
                       input logic [63:0] exp, input logic to_int);
        drive(op, sp, 5'd3, res, 4'b0);
        step();
        check({tag, "_valid"}, 64'(WB_VALID), 64'd1);
        check({tag, "_data"}, WB_DATA, exp);
        check({tag, "_toint"}, 64'(WB_TO_INT), 64'(to_int));
    endtask

    initial begin
        RST       = 1'b1;
        FLUSH     = 1'b0;
        WB_READY  = 1'b0;
        CSR_WE    = 1'b0;
        CSR_WDATA = 5'b0;
        IN_OPERATION = 3'b0;
        IN_SP_DP  = 1'b0;
        IN_RD     = 5'b0;
        IN_RESULT = 64'b0;
        idle_in();
        step();
        step();
        check("rst_wbvalid", 64'(WB_VALID), 64'd0);
        check("rst_wbdata", WB_DATA, 64'd0);
        RST = 1'b0;
        step();
        check("idle_inready", 64'(IN_READY), 64'd1);
        check("idle_wbvalid", 64'(WB_VALID), 64'd0);
        check("idle_fflags", 64'(FFLAGS), 64'd0);

        // FP->int with NV set.
        WB_READY = 1'b1;
        drive(3'b000, 1'b0, 5'd7, 64'h0000_0000_8000_0000, 4'b1000);
        step();
        idle_in();
        check("f2i_valid", 64'(WB_VALID), 64'd1);
        check("f2i_data", WB_DATA, 64'hFFFF_FFFF_8000_0000);
        check("f2i_toint", 64'(WB_TO_INT), 64'd1);
        check("f2i_rd", 64'(WB_RD), 64'd7);
        check("f2i_nofl", 64'(FFLAGS), 64'd0);
        step();
        check("f2i_ret", 64'(WB_VALID), 64'd0);
        check("f2i_fflags", 64'(FFLAGS), 64'b10000);

        // Formatting table, one result per cycle.
        fmt("i2f_sp", 3'b010, 1'b0, 64'h0000_0000_3F80_0000,
            64'hFFFF_FFFF_3F80_0000, 1'b0);
        fmt("s2d", 3'b111, 1'b0, 64'h3FF0_0000_0000_0000,
            64'h3FF0_0000_0000_0000, 1'b0);
        fmt("d2s", 3'b111, 1'b1, 64'h1234_5678_3F80_0000,
            64'hFFFF_FFFF_3F80_0000, 1'b0);
        fmt("f2iu", 3'b001, 1'b1, 64'hDEAD_BEEF_7FFF_FFFF,
            64'h0000_0000_7FFF_FFFF, 1'b1);
        fmt("i2f_dp", 3'b011, 1'b1, 64'h4000_0000_0000_0000,
            64'h4000_0000_0000_0000, 1'b0);
        fmt("sgnj_sp", 3'b101, 1'b0, 64'hAAAA_AAAA_BF80_0000,
            64'hFFFF_FFFF_BF80_0000, 1'b0);
        fmt("sgnj_dp", 3'b110, 1'b1, 64'h8000_0000_0000_0001,
            64'h8000_0000_0000_0001, 1'b0);
        idle_in();
        step();
        check("fmt_drain", 64'(WB_VALID), 64'd0);
        check("fmt_fflags", 64'(FFLAGS), 64'b10000);
        CSR_WE = 1'b1;
        CSR_WDATA = 5'b0;
        step();
        CSR_WE = 1'b0;
        check("csr_clr", 64'(FFLAGS), 64'd0);

        // Backpressure: three offered, two accepted.
        WB_READY = 1'b0;
        drive(3'b100, 1'b1, 5'd1, 64'h1111_1111_1111_1111, 4'b0);
        step();
        check("bp1_ready", 64'(IN_READY), 64'd1);
        check("bp1_data", WB_DATA, 64'h1111_1111_1111_1111);
        drive(3'b100, 1'b1, 5'd2, 64'h2222_2222_2222_2222, 4'b0);
        step();
        check("bp2_ready", 64'(IN_READY), 64'd0);
        check("bp2_rd", 64'(WB_RD), 64'd1);
        drive(3'b100, 1'b1, 5'd3, 64'h3333_3333_3333_3333, 4'b0);
        step();
        check("bp3_ready", 64'(IN_READY), 64'd0);
        check("bp3_data", WB_DATA, 64'h1111_1111_1111_1111);
        check("bp3_rd", 64'(WB_RD), 64'd1);
        idle_in();
        WB_READY = 1'b1;
        step();
        check("bp_ret1_valid", 64'(WB_VALID), 64'd1);
        check("bp_ret1_rd", 64'(WB_RD), 64'd2);
        check("bp_ret1_data", WB_DATA, 64'h2222_2222_2222_2222);
        check("bp_ret1_ready", 64'(IN_READY), 64'd1);
        step();
        check("bp_ret2_valid", 64'(WB_VALID), 64'd0);

        // CSR write coincident with retirement keeps retiring flags.
        WB_READY = 1'b0;
        drive(3'b010, 1'b0, 5'd4, 64'h0000_0000_3F80_0001, 4'b0001);
        step();
        idle_in();
        check("nx_pend", 64'(FFLAGS), 64'd0);
        WB_READY = 1'b1;
        CSR_WE = 1'b1;
        CSR_WDATA = 5'b0;
        step();
        CSR_WE = 1'b0;
        check("nx_csr", 64'(FFLAGS), 64'b00001);

        // Flush with two flagged entries buffered.
        WB_READY = 1'b0;
        drive(3'b010, 1'b0, 5'd8, 64'h5, 4'b0100);
        step();
        drive(3'b010, 1'b0, 5'd9, 64'h6, 4'b0010);
        step();
        check("fl_full", 64'(IN_READY), 64'd0);
        FLUSH = 1'b1;
        WB_READY = 1'b1;
        #1;
        check("fl_comb", 64'(WB_VALID), 64'd0);
        step();
        FLUSH = 1'b0;
        idle_in();
        #1;
        check("fl_empty", 64'(WB_VALID), 64'd0);
        check("fl_ready", 64'(IN_READY), 64'd1);
        check("fl_fflags", 64'(FFLAGS), 64'b00001);

        // Flush drops same-cycle input; CSR write still lands.
        drive(3'b010, 1'b0, 5'd10, 64'h7, 4'b1000);
        FLUSH = 1'b1;
        CSR_WE = 1'b1;
        CSR_WDATA = 5'b00100;
        step();
        FLUSH = 1'b0;
        CSR_WE = 1'b0;
        idle_in();
        check("fl_drop", 64'(WB_VALID), 64'd0);
        check("fl_csr", 64'(FFLAGS), 64'b00100);

        // Reset wins over CSR write.
        RST = 1'b1;
        CSR_WE = 1'b1;
        CSR_WDATA = 5'b11111;
        step();
        RST = 1'b0;
        CSR_WE = 1'b0;
        check("rst_csr", 64'(FFLAGS), 64'd0);
        check("rst_ready", 64'(IN_READY), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
